// File: rtl/keyproc_queue_pkg.sv
// Shared instruction codes and default parameters for the function-key front end.
package keyproc_pkg;

  localparam int CODE_W_DEF = 4;

  localparam logic [3:0] INSTR_NONE     = 4'd0;
  localparam logic [3:0] INSTR_NORTH    = 4'd1;
  localparam logic [3:0] INSTR_EAST     = 4'd2;
  localparam logic [3:0] INSTR_WEST     = 4'd3;
  localparam logic [3:0] INSTR_SOUTH    = 4'd4;
  localparam logic [3:0] INSTR_SCRAMBLE = 4'd5;

  // Slice i is the code for key i; key 0 is the scramble key and has no code.
  localparam logic [5*CODE_W_DEF-1:0] KEY_CODES_DEF =
    {INSTR_EAST, INSTR_WEST, INSTR_NORTH, INSTR_SOUTH, INSTR_NONE};

endpackage

// File: rtl/keyproc_queue_if.sv
// Instruction queue handshake between the key processor and the tile/grid controller.
interface keyproc_queue_if #(
  parameter int CODE_W = 4
);
  logic              instr_valid;
  logic              instr_ready;
  logic [CODE_W-1:0] instruction;

  modport master (output instr_valid, output instruction, input instr_ready);
  modport slave  (input instr_valid, input instruction, output instr_ready);
endinterface

// File: rtl/keyproc_queue_key_debounce.sv
// One key: 2-flop synchroniser, debounce counter, debounced level and one-cycle rise pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[0], key_raw};
    cnt_d  = '0;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    if (sync_q[1] != lvl_q) begin
      // The sample that would bring the count to DEBOUNCE_CYCLES flips the state.
      if (cnt_q == CNT_LAST) begin
        lvl_d  = ~lvl_q;
        rise_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
    end
  end

  assign level = lvl_q;
  assign rise  = rise_q;

endmodule

// File: rtl/keyproc_queue.sv
// Key-command processor: debounced keys -> priority-encoded press/auto-repeat events -> instruction FIFO.
module keyproc_queue
  import keyproc_pkg::*;
#(
  parameter int NUM_KEYS        = 5,
  parameter int CODE_W          = CODE_W_DEF,
  parameter logic [NUM_KEYS*CODE_W-1:0] KEY_CODES = KEY_CODES_DEF,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         keys,
  keyproc_queue_if.master             instr_if,
  output logic                        scramble,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fill
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int KW = $clog2(NUM_KEYS);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] lvl, rise;
  logic                unused_rise0;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (sysclk),
      .rst    (reset),
      .key_raw(keys[g]),
      .level  (lvl[g]),
      .rise   (rise[g])
    );
  end
  assign unused_rise0 = rise[0];

  logic [KW-1:0]     trk_q, trk_d, win;
  logic              trk_vld_q, trk_vld_d, win_vld;
  logic              first_q, first_d;
  logic [31:0]       rpt_q, rpt_d, rpt_lim;
  logic              ev_q, ev_d;
  logic [CODE_W-1:0] ev_code_q, ev_code_d;
  logic              scr_q, scr_d, ovf_q, ovf_d;
  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [CODE_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              push, pop;

  // Ascending scan: the highest rising key index is left in win.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 1; i < NUM_KEYS; i++) begin
      if (rise[i]) begin
        win     = KW'(i);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    rpt_lim   = first_q ? 32'(REPEAT_DELAY) : 32'(REPEAT_PERIOD);
    trk_d     = trk_q;
    trk_vld_d = trk_vld_q;
    first_d   = first_q;
    rpt_d     = rpt_q;
    ev_d      = 1'b0;
    ev_code_d = ev_code_q;
    if (win_vld) begin
      trk_d     = win;
      trk_vld_d = 1'b1;
      first_d   = 1'b1;
      rpt_d     = '0;
      ev_d      = 1'b1;
      ev_code_d = KEY_CODES[int'(win)*CODE_W +: CODE_W];
    end else if (trk_vld_q && !lvl[trk_q]) begin
      trk_vld_d = 1'b0;
      rpt_d     = '0;
    end else if (trk_vld_q && REPEAT_PERIOD != 0) begin
      if (rpt_q == rpt_lim - 1) begin
        rpt_d     = '0;
        first_d   = 1'b0;
        ev_d      = 1'b1;
        ev_code_d = KEY_CODES[int'(trk_q)*CODE_W +: CODE_W];
      end else begin
        rpt_d = rpt_q + 1;
      end
    end
  end

  // A full queue still accepts a push when the head pops on the same edge.
  always_comb begin
    pop   = (cnt_q != '0) && instr_if.instr_ready;
    push  = ev_q && ((cnt_q != DEPTH) || pop);
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q | (ev_q & ~push);
    scr_d = lvl[0];
    if (push) begin
      mem_d[wr_q] = ev_code_q;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      trk_q     <= '0;
      trk_vld_q <= 1'b0;
      first_q   <= 1'b0;
      rpt_q     <= '0;
      ev_q      <= 1'b0;
      ev_code_q <= '0;
      scr_q     <= 1'b0;
      ovf_q     <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      trk_q     <= trk_d;
      trk_vld_q <= trk_vld_d;
      first_q   <= first_d;
      rpt_q     <= rpt_d;
      ev_q      <= ev_d;
      ev_code_q <= ev_code_d;
      scr_q     <= scr_d;
      ovf_q     <= ovf_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      mem_q     <= mem_d;
    end
  end

  assign instr_if.instr_valid = (cnt_q != '0);
  assign instr_if.instruction = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign scramble             = scr_q;
  assign overflow             = ovf_q;
  assign fill                 = cnt_q;

endmodule

// File: tb/tb_keyproc_queue.sv
// Directed bench for keyproc_queue with short debounce/repeat timing and hand-computed expectations.
module tb_keyproc_queue;

  localparam int DC = 4;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [4:0] keys;
  logic       scramble, overflow;
  logic [2:0] fill;
  int         checks = 0;
  int         errors = 0;

  keyproc_queue_if #(.CODE_W(4)) q_if ();

  keyproc_queue #(
    .NUM_KEYS(5), .CODE_W(4), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .FIFO_DEPTH(4)
  ) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .keys    (keys),
    .instr_if(q_if),
    .scramble(scramble),
    .overflow(overflow),
    .fill    (fill)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples land 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic press(input int k);
    keys[k] = 1'b1;
    tick(8);
    keys[k] = 1'b0;
    tick(10);
  endtask

  initial begin
    int seq6 [6] = '{1, 2, 3, 4, 1, 2};
    int drain4 [4] = '{4, 1, 3, 2};
    int drain5 [4] = '{1, 3, 2, 4};
    logic exp_v;

    reset = 1'b1;
    keys = '0;
    q_if.instr_ready = 1'b1;
    tick(3);
    chk("rst_valid", 32'(q_if.instr_valid), 0);
    chk("rst_instr", 32'(q_if.instruction), 0);
    chk("rst_scramble", 32'(scramble), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_fill", 32'(fill), 0);
    reset = 1'b0;
    tick(2);

    // Single press: first sampled at edge k, visible after edge k+DC+3, popped one edge later.
    keys[2] = 1'b1;
    tick(DC + 3);
    chk("t1_valid_early", 32'(q_if.instr_valid), 0);
    tick(1);
    chk("t1_valid", 32'(q_if.instr_valid), 1);
    chk("t1_instr", 32'(q_if.instruction), 1);
    chk("t1_fill", 32'(fill), 1);
    tick(1);
    chk("t1_popped_valid", 32'(q_if.instr_valid), 0);
    chk("t1_popped_fill", 32'(fill), 0);
    keys[2] = 1'b0;
    tick(30);
    chk("t1_release_fill", 32'(fill), 0);
    keys[2] = 1'b1;
    tick(3);
    keys[2] = 1'b0;
    tick(20);
    chk("t1_glitch_valid", 32'(q_if.instr_valid), 0);
    chk("t1_glitch_fill", 32'(fill), 0);

    // Simultaneous rise: highest index wins; the loser stays silent while held.
    q_if.instr_ready = 1'b0;
    keys[4] = 1'b1;
    keys[1] = 1'b1;
    tick(8);
    chk("t2_fill", 32'(fill), 1);
    chk("t2_instr", 32'(q_if.instruction), 2);
    keys[4] = 1'b0;
    tick(30);
    chk("t2_held_fill", 32'(fill), 1);
    q_if.instr_ready = 1'b1;
    keys[1] = 1'b0;
    tick(1);
    chk("t2_drain_fill", 32'(fill), 0);
    chk("t2_drain_valid", 32'(q_if.instr_valid), 0);
    tick(15);

    // Auto-repeat: entries after edges k+7, then +20, then every +8 until the debounced fall.
    keys[3] = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      exp_v = (i == 7) || (i == 27) || (i == 35) || (i == 43) || (i == 51) || (i == 59);
      chk($sformatf("t3_valid_k%0d", i), 32'(q_if.instr_valid), 32'(exp_v));
      if (exp_v) chk($sformatf("t3_instr_k%0d", i), 32'(q_if.instruction), 3);
      if (i == 59) keys[3] = 1'b0;
    end
    tick(10);

    // Full queue: pop and push on the same edge keeps fill at 4 with no overflow.
    q_if.instr_ready = 1'b0;
    for (int i = 1; i < 5; i++) press(i);
    chk("t5_full_fill", 32'(fill), 4);
    chk("t5_full_head", 32'(q_if.instruction), 4);
    chk("t5_full_ovf", 32'(overflow), 0);
    keys[1] = 1'b1;
    tick(DC + 3);
    q_if.instr_ready = 1'b1;
    tick(1);
    q_if.instr_ready = 1'b0;
    chk("t5_swap_fill", 32'(fill), 4);
    chk("t5_swap_ovf", 32'(overflow), 0);
    chk("t5_swap_head", 32'(q_if.instruction), 1);
    keys[1] = 1'b0;
    tick(10);
    q_if.instr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t5_drain%0d", j), 32'(q_if.instruction), 32'(drain5[j]));
      tick(1);
    end
    chk("t5_empty_fill", 32'(fill), 0);
    chk("t5_empty_instr", 32'(q_if.instruction), 0);
    tick(5);

    // Overflow: six presses into a stalled queue keep the first four in order.
    q_if.instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) press(seq6[i]);
    chk("t4_fill", 32'(fill), 4);
    chk("t4_ovf", 32'(overflow), 1);
    q_if.instr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t4_drain%0d", j), 32'(q_if.instruction), 32'(drain4[j]));
      chk($sformatf("t4_fill%0d", j), 32'(fill), 32'(4 - j));
      tick(1);
    end
    chk("t4_empty_fill", 32'(fill), 0);
    chk("t4_empty_valid", 32'(q_if.instr_valid), 0);
    chk("t4_ovf_sticky", 32'(overflow), 1);

    // Scramble key and mid-operation reset.
    q_if.instr_ready = 1'b0;
    keys[0] = 1'b1;
    tick(10);
    chk("t6_scramble", 32'(scramble), 1);
    chk("t6_scr_no_entry", 32'(fill), 0);
    for (int i = 1; i < 4; i++) press(i);
    chk("t6_fill3", 32'(fill), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(q_if.instr_valid), 0);
    chk("t6_rst_instr", 32'(q_if.instruction), 0);
    chk("t6_rst_scramble", 32'(scramble), 0);
    chk("t6_rst_ovf", 32'(overflow), 0);
    chk("t6_rst_fill", 32'(fill), 0);
    tick(2);
    reset = 1'b0;
    tick(DC + 2);
    chk("t6_scr_early", 32'(scramble), 0);
    tick(1);
    chk("t6_scr_back", 32'(scramble), 1);
    chk("t6_post_valid", 32'(q_if.instr_valid), 0);
    chk("t6_post_fill", 32'(fill), 0);
    chk("t6_post_ovf", 32'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
